// File: rtl/mmio_core_mux.sv
// mmio_core_mux
//   MMIO sub-decoder and response sequencer. Decodes the core prefix in
//   cpu_addr[29:24] against CORE_PREFIXES, drives one core at a time with a
//   registered chip-select, waits for that core's ready and returns a single
//   registered cpu_ready pulse with read data. Unmapped prefixes complete
//   immediately with zero data and set a sticky bus error.
//
//   Optional feature macro: MMIO_TIMEOUT_EN
//     defined   : ACCESS is bounded to TIMEOUT_CYCLES cycles; expiry completes
//                 with zero data and records a bus error.
//     undefined : ACCESS waits indefinitely for the selected core.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb  CPU request (wstrb != 0 means write)
//   force_trap                  complete with illegal-instruction word (0)
//   cpu_ready, cpu_rdata        one-cycle completion pulse and read data
//   core_cs, core_we            one-hot core select, first-cycle write enable
//   core_address               latched cpu_addr[9:2]
//   core_write_data            latched cpu_wdata
//   core_read_data, core_ready  per-core read data and ready
//   error_clear                 clears bus_error
//   bus_error, error_addr       sticky error flag and first erroring address
//
// FSM states
//   state     | meaning
//   ST_IDLE   | waiting for cpu_valid, decodes prefix
//   ST_ACCESS | selected core's cs held high until its ready (or timeout)
//   ST_RESP   | cpu_ready high for this single cycle

module mmio_core_mux #(
   parameter int                     NUM_CORES      = 8,
   parameter logic [NUM_CORES*6-1:0] CORE_PREFIXES  = {NUM_CORES{6'h3f}},
   parameter int                     TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_valid,
   input  logic [31:0]               cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic [3:0]                cpu_wstrb,
   input  logic                      force_trap,
   output logic                      cpu_ready,
   output logic [31:0]               cpu_rdata,
   output logic [NUM_CORES-1:0]      core_cs,
   output logic                      core_we,
   output logic [7:0]                core_address,
   output logic [31:0]               core_write_data,
   input  logic [NUM_CORES*32-1:0]   core_read_data,
   input  logic [NUM_CORES-1:0]      core_ready,
   input  logic                      error_clear,
   output logic                      bus_error,
   output logic [31:0]               error_addr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [NUM_CORES-1:0]  match_vec;
   logic                  hit;
   logic                  sel_ready;
   logic [31:0]           sel_rdata;
   logic                  timeout_hit;

   logic                  load_req;
   logic                  go_access;
   logic                  resp_zero;
   logic                  capture;
   logic                  err_set;
   logic [31:0]           err_addr_src;

   // Prefix decode; duplicate table entries are illegal so no priority needed.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (cpu_addr[29:24] == CORE_PREFIXES[6*i +: 6]) match_vec[i] = 1'b1;
      end
   end

   assign hit = |match_vec;

   // core_cs is one-hot while in ACCESS, so it doubles as the response mux select
   // and masks out ready from unselected cores.
   assign sel_ready = |(core_ready & core_cs);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_cs[i]) sel_rdata = sel_rdata | core_read_data[32*i +: 32];
      end
   end

`ifdef MMIO_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic [31:0] addr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
         addr_q  <= '0;
      end else begin
         if (go_access)
            tmo_cnt <= '0;
         else if (state == ST_ACCESS)
            tmo_cnt <= tmo_cnt + 16'd1;
         if (load_req)
            addr_q <= cpu_addr;
      end
   end

   // tmo_cnt holds the number of ACCESS cycles already completed, so this fires
   // in the TIMEOUT_CYCLES-th ACCESS cycle.
   assign timeout_hit = (state == ST_ACCESS) &&
                        (({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_next   = state;
      load_req     = 1'b0;
      go_access    = 1'b0;
      resp_zero    = 1'b0;
      capture      = 1'b0;
      err_set      = 1'b0;
      err_addr_src = cpu_addr;
      case (state)
         ST_IDLE: begin
            if (cpu_valid) begin
               load_req = 1'b1;
               if (force_trap) begin
                  resp_zero  = 1'b1;
                  state_next = ST_RESP;
               end else if (hit) begin
                  go_access  = 1'b1;
                  state_next = ST_ACCESS;
               end else begin
                  resp_zero  = 1'b1;
                  err_set    = 1'b1;
                  state_next = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            if (sel_ready) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end else if (timeout_hit) begin
               resp_zero  = 1'b1;
               err_set    = 1'b1;
`ifdef MMIO_TIMEOUT_EN
               err_addr_src = addr_q;
`endif
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         cpu_ready       <= 1'b0;
         cpu_rdata       <= '0;
         core_cs         <= '0;
         core_we         <= 1'b0;
         core_address    <= '0;
         core_write_data <= '0;
         bus_error       <= 1'b0;
         error_addr      <= '0;
      end else begin
         state     <= state_next;
         // RESP always exits to IDLE, so this can never be high twice in a row.
         cpu_ready <= (state_next == ST_RESP);
         core_we   <= go_access && (cpu_wstrb != 4'h0);

         if (load_req) begin
            core_address    <= cpu_addr[9:2];
            core_write_data <= cpu_wdata;
         end

         if (go_access)
            core_cs <= match_vec;
         else if (state_next != ST_ACCESS)
            core_cs <= '0;

         if (capture)
            cpu_rdata <= sel_rdata;
         else if (resp_zero)
            cpu_rdata <= '0;

         // A new error beats a simultaneous clear and re-captures the address.
         if (err_set) begin
            bus_error <= 1'b1;
            if (!bus_error || error_clear)
               error_addr <= err_addr_src;
         end else if (error_clear) begin
            bus_error <= 1'b0;
         end
      end
   end

endmodule
